// File: rtl/pipeline_fetch_queue.sv
// Fetch stage: issues imem reads, buffers in-order responses in a
// prefetch queue and drives the IF/ID register consumed by decode.
module pipeline_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic [15:0] IR_out,
    output logic [7:0]  PC_out,
    output logic        inst_valid,
    output logic        halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [7:0]    pc_ent_q [DEPTH];
    logic [15:0]   ir_ent_q [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fill_ptr_q, fill_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [7:0]    fetch_pc_q, fetch_pc_d;
    logic          halted_q, halted_d;
    logic [15:0]   ir_q, ir_d;
    logic [7:0]    pc_q, pc_d;
    logic          valid_q, valid_d;

    logic [CW-1:0] used;
    logic [CW-1:0] unfilled;
    logic [CW-1:0] rsp_dec;
    logic [CW:0]   credit;
    logic          head_filled;
    logic          issue;
    logic          rsp_fill;
    logic          rsp_drop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] rd_idx;

    // Pointers carry one extra wrap bit so differences give true counts.
    assign used        = wr_ptr_q - rd_ptr_q;
    assign unfilled    = wr_ptr_q - fill_ptr_q;
    assign credit      = {1'b0, used} + {1'b0, discard_q};
    assign head_filled = (fill_ptr_q != rd_ptr_q);
    assign rsp_drop    = imem_valid && (discard_q != '0);
    assign rsp_fill    = imem_valid && (discard_q == '0);
    assign rsp_dec     = {{(CW-1){1'b0}}, imem_valid};
    assign wr_idx      = wr_ptr_q[AW-1:0];
    assign fill_idx    = fill_ptr_q[AW-1:0];
    assign rd_idx      = rd_ptr_q[AW-1:0];

    assign issue = !halted_q && !redirect_valid
                && (credit < DEPTH_C);

    assign imem_req   = issue && rst_n;
    assign imem_addr  = fetch_pc_q;
    assign IR_out     = ir_q;
    assign PC_out     = pc_q;
    assign inst_valid = valid_q;
    assign halted     = halted_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (redirect_valid) begin
            // Every unfilled entry still owes a response to the old stream.
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            discard_d  = discard_q + unfilled - rsp_dec;
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            ir_d       = 16'h0000;
            valid_d    = 1'b0;
        end else begin
            if (issue) begin
                wr_ptr_d   = wr_ptr_q + CW'(1);
                fetch_pc_d = fetch_pc_q + 8'd1;
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (rsp_fill) begin
                fill_ptr_d = fill_ptr_q + CW'(1);
                if (imem_rdata[15:13] == 3'b111) begin
                    halted_d = 1'b1;
                end
            end
            if (!stall) begin
                if (head_filled) begin
                    ir_d     = ir_ent_q[rd_idx];
                    pc_d     = pc_ent_q[rd_idx];
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end else begin
                    ir_d    = 16'h0000;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_ent_q[wr_idx] <= fetch_pc_q;
        end
        if (rsp_fill && !redirect_valid) begin
            ir_ent_q[fill_idx] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            discard_q  <= '0;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            ir_q       <= 16'h0000;
            pc_q       <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            discard_q  <= discard_d;
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule
